// File: rtl/shift_result_display.sv
// Four-digit multiplexed seven-segment readout of the last captured barrel-shifter
// result (hex, digits 1:0), its shift amount (digit 2) and direction (digit 3).
module shift_result_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic [2:0] shift,
    input  logic       lr,
    input  logic       load,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int             CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    localparam logic [1:0] D0 = 2'd0;
    localparam logic [1:0] D1 = 2'd1;
    localparam logic [1:0] D2 = 2'd2;
    localparam logic [1:0] D3 = 2'd3;

    localparam logic [6:0] GLYPH_L = 7'h38;
    localparam logic [6:0] GLYPH_R = 7'h50;

    // XOR masks that turn active-high patterns into the board's drive polarity
    localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [3:0] AN_POL  = {4{ACTIVE_LOW}};
    localparam logic       DP_POL  = ACTIVE_LOW;

    logic [7:0]       cap_val_q, cap_val_d;
    logic [2:0]       cap_sh_q,  cap_sh_d;
    logic             cap_lr_q,  cap_lr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       idx_q,     idx_d;
    logic [6:0]       seg_q,     seg_d;
    logic             dp_q,      dp_d;
    logic [3:0]       an_q,      an_d;

    logic       term;
    logic       stale;
    logic [6:0] glyph;
    logic [3:0] an_sel;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h3F;
            4'h1: r = 7'h06;
            4'h2: r = 7'h5B;
            4'h3: r = 7'h4F;
            4'h4: r = 7'h66;
            4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;
            4'h7: r = 7'h07;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h6F;
            4'hA: r = 7'h77;
            4'hB: r = 7'h7C;
            4'hC: r = 7'h39;
            4'hD: r = 7'h5E;
            4'hE: r = 7'h79;
            default: r = 7'h71;
        endcase
        return r;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_an_sel
            assign an_sel[gi] = (idx_q == 2'(gi));
        end
    endgenerate

    always_comb begin
        cap_val_d = cap_val_q;
        cap_sh_d  = cap_sh_q;
        cap_lr_d  = cap_lr_q;
        if (load) begin
            cap_val_d = in;
            cap_sh_d  = shift;
            cap_lr_d  = lr;
        end

        term  = (cnt_q == CNT_LAST);
        cnt_d = term ? '0 : cnt_q + CNT_W'(1);
        idx_d = term ? idx_q + 2'd1 : idx_q;

        case (idx_q)
            D0:      glyph = hex7(cap_val_q[3:0]);
            D1:      glyph = hex7(cap_val_q[7:4]);
            D2:      glyph = hex7({1'b0, cap_sh_q});
            default: glyph = cap_lr_q ? GLYPH_R : GLYPH_L;
        endcase

        // Live shifter output compared against what is on display
        stale = ({in, shift, lr} != {cap_val_q, cap_sh_q, cap_lr_q});

        seg_d = glyph ^ SEG_POL;
        an_d  = an_sel ^ AN_POL;
        dp_d  = ((idx_q == D3) && stale) ^ DP_POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_val_q <= '0;
            cap_sh_q  <= '0;
            cap_lr_q  <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= D0;
            seg_q     <= 7'h3F ^ SEG_POL;
            an_q      <= 4'b0001 ^ AN_POL;
            dp_q      <= DP_POL;
        end else begin
            cap_val_q <= cap_val_d;
            cap_sh_q  <= cap_sh_d;
            cap_lr_q  <= cap_lr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            dp_q      <= dp_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_shift_result_display.sv
// Self-checking bench for shift_result_display: literal vector table, hand-written
// scan/stale/reset sequences and randomized traffic against a timeline model.
module tb_shift_result_display;

    localparam int DIV = 4;
    localparam bit AL  = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_v = 8'h00;
    logic [2:0] shift_v = 3'd0;
    logic       lr = 1'b0;
    logic       load = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    always #5 clk = ~clk;

    shift_result_display #(.REFRESH_DIV(DIV), .ACTIVE_LOW(AL)) dut (
        .clk(clk), .rst(rst), .in(in_v), .shift(shift_v), .lr(lr), .load(load),
        .seg(seg), .dp(dp), .an(an)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: captured command plus edges elapsed since reset
    logic [6:0] hex_tab [16];
    logic [7:0] m_val;
    logic [2:0] m_sh;
    logic       m_lr;
    int         m_t;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;

    typedef struct {
        logic [7:0] v;
        logic [2:0] s;
        logic       l;
        int         digit;
        logic [6:0] seg;
    } vec_t;
    vec_t vecs [10];

    logic [3:0] scan_pat [4];
    logic [6:0] seg_9a [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d, input logic [7:0] v,
                                         input logic [2:0] s, input logic l);
        case (d)
            0: return hex_tab[v[3:0]];
            1: return hex_tab[v[7:4]];
            2: return hex_tab[{1'b0, s}];
            default: return l ? 7'h50 : 7'h38;
        endcase
    endfunction

    // One clock edge: advance the model with the inputs present at the edge, then compare
    task automatic tick();
        int d;
        logic stale;
        if (rst) begin
            m_t = 0; m_val = '0; m_sh = '0; m_lr = 1'b0;
            e_seg = AL ? ~7'h3F : 7'h3F;
            e_an  = AL ? ~4'b0001 : 4'b0001;
            e_dp  = AL;
        end else begin
            d = (m_t / DIV) % 4;
            stale = (in_v != m_val) || (shift_v != m_sh) || (lr != m_lr);
            e_seg = glyph(d, m_val, m_sh, m_lr) ^ {7{AL}};
            e_an  = (4'b0001 << d) ^ {4{AL}};
            e_dp  = ((d == 3) && stale) ^ AL;
            m_t = (m_t + 1) % (4 * DIV);
            if (load) begin
                m_val = in_v; m_sh = shift_v; m_lr = lr;
            end
        end
        @(posedge clk);
        #1;
        check("model_seg", {25'd0, seg}, {25'd0, e_seg});
        check("model_an", {28'd0, an}, {28'd0, e_an});
        check("model_dp", {31'd0, dp}, {31'd0, e_dp});
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        int n = 0;
        while (an !== target && n < 4 * DIV + 4) begin
            tick();
            n++;
        end
        check(name, {28'd0, an}, {28'd0, target});
    endtask

    function automatic int digit_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            default: return 3;
        endcase
    endfunction

    initial begin
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        scan_pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_9a   = '{7'b0001000, 7'b0010000, 7'b1000000, 7'b1000111};
        vecs[0] = '{8'b10011010, 3'd0, 1'b0, 0, 7'b0001000};
        vecs[1] = '{8'b10011010, 3'd0, 1'b0, 1, 7'b0010000};
        vecs[2] = '{8'b10011010, 3'd0, 1'b0, 2, 7'b1000000};
        vecs[3] = '{8'b10011010, 3'd0, 1'b0, 3, 7'b1000111};
        vecs[4] = '{8'h9A, 3'd7, 1'b1, 2, 7'b1111000};
        vecs[5] = '{8'h9A, 3'd7, 1'b1, 3, 7'b0101111};
        vecs[6] = '{8'h35, 3'd3, 1'b0, 0, 7'b0010010};
        vecs[7] = '{8'h35, 3'd3, 1'b0, 1, 7'b0110000};
        vecs[8] = '{8'hFE, 3'd5, 1'b1, 0, 7'b0000110};
        vecs[9] = '{8'hFE, 3'd5, 1'b1, 1, 7'b0001110};

        // Reset values and first digit change
        rst = 1'b1;
        tick();
        tick();
        check("rst_an", {28'd0, an}, 32'b1110);
        check("rst_seg", {25'd0, seg}, 32'b1000000);
        check("rst_dp", {31'd0, dp}, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_d0_dwell", {28'd0, an}, 32'b1110);
        end
        tick();
        check("post_rst_first_change", {28'd0, an}, 32'b1101);

        // Literal decode table
        foreach (vecs[k]) begin
            in_v = vecs[k].v; shift_v = vecs[k].s; lr = vecs[k].l; load = 1'b1;
            tick();
            load = 1'b0;
            tick();
            wait_an(~(4'b0001 << vecs[k].digit), "vec_wait_digit");
            check("vec_seg", {25'd0, seg}, {25'd0, vecs[k].seg});
            check("vec_dp", {31'd0, dp}, 32'd1);
        end

        // Scan sequence: each digit held exactly DIV cycles, two full periods
        wait_an(4'b0111, "scan_wait_d3");
        wait_an(4'b1110, "scan_wait_d0");
        for (int i = 0; i < 8 * DIV; i++) begin
            check("scan_an", {28'd0, an}, {28'd0, scan_pat[(i / DIV) % 4]});
            tick();
        end

        // Stale indicator
        in_v = 8'h9A; shift_v = 3'd0; lr = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        in_v = 8'h35;
        for (int i = 0; i < 4 * DIV; i++) begin
            tick();
            check("stale_dp", {31'd0, dp}, (an == 4'b0111) ? 32'd0 : 32'd1);
            check("stale_seg_held", {25'd0, seg}, {25'd0, seg_9a[digit_of(an)]});
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3 * DIV; i++) begin
            tick();
            check("reloaded_dp", {31'd0, dp}, 32'd1);
        end

        // Reset beats load, mid-scan
        wait_an(4'b1011, "midrst_wait_d2");
        in_v = 8'hFF; shift_v = 3'd7; lr = 1'b1; load = 1'b1; rst = 1'b1;
        tick();
        check("midrst_an", {28'd0, an}, 32'b1110);
        check("midrst_seg", {25'd0, seg}, 32'b1000000);
        check("midrst_dp", {31'd0, dp}, 32'd1);
        rst = 1'b0; load = 1'b0; in_v = 8'h00; shift_v = 3'd0; lr = 1'b0;
        for (int i = 0; i < DIV; i++) begin
            tick();
            check("midrst_d0_dwell", {28'd0, an}, 32'b1110);
        end
        tick();
        check("midrst_d1_an", {28'd0, an}, 32'b1101);
        check("midrst_cap_zero", {25'd0, seg}, 32'b1000000);
        wait_an(4'b0111, "midrst_wait_d3");
        check("midrst_lr_zero", {25'd0, seg}, 32'b1000111);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1) == 0) begin
                in_v = 8'($urandom);
                shift_v = 3'($urandom);
                lr = 1'($urandom);
            end
            load = ($urandom_range(3) == 0);
            rst = ($urandom_range(63) == 0);
            tick();
        end
        rst = 1'b0; load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_result_display.md
# shift_result_display

Drives a 4-digit multiplexed seven-segment display with the most recent barrel-shifter result and the command that produced it. It sits directly downstream of the 8-bit barrel shifter and consumes its 8-bit output together with the 3-bit shift amount and the direction bit. Digits 1:0 show the result in hex, digit 2 shows the shift amount, and digit 3 shows the direction (`L`/`r`). A stale indicator shows when the live shifter output no longer matches the captured value.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Legal range is 1 or more.
- `ACTIVE_LOW`, default 1: when 1, `seg`, `dp` and `an` are all inverted (a lit segment or enabled digit is driven 0).

Ports:
- `clk` input, 1 bit: the single clock. Everything is on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `in` input, 8 bits: result from the barrel shifter.
- `shift` input, 3 bits: shift amount applied to produce `in`.
- `lr` input, 1 bit: direction applied. 0 displays `L`, 1 displays `r`.
- `load` input, 1 bit: capture strobe, level-sensitive. `in`, `shift` and `lr` are sampled on every edge where it is high.
- `seg` output, 7 bits: segment drive, `seg[0]`=a through `seg[6]`=g.
- `dp` output, 1 bit: decimal point.
- `an` output, 4 bits: digit enables, `an[0]` = rightmost digit.

## Operation
- **Capture registers** `cap_val[7:0]`, `cap_sh[2:0]`, `cap_lr`:
  - reset to 0;
  - load on an edge with `load`=1 and `rst`=0;
  - otherwise hold their value.
- **Refresh counter**:
  - width is $clog2(REFRESH_DIV), minimum 1 bit;
  - counts 0 to REFRESH_DIV-1, then wraps to 0;
  - reset clears it to 0.
  - With REFRESH_DIV=1 it stays at 0 and the digit advances every cycle.
- **Digit index** (2-bit state, states D0 → D1 → D2 → D3 → D0):
  - advances on the edge where the counter equals REFRESH_DIV-1;
  - reset sets it to D0.
- **Digit content** (active-high gfedcba encodings):

  | Digit | Shows |
  |---|---|
  | D0 | hex of `cap_val[3:0]` |
  | D1 | hex of `cap_val[7:4]` |
  | D2 | hex of `cap_sh` (0..7) |
  | D3 | `L` (0x38) if `cap_lr`=0, `r` (0x50) if `cap_lr`=1 |

- **Hex encodings**: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- **`an`**: exactly one digit is enabled, the one matching the index (one-hot, active-high before polarity is applied).
- **`dp`**:
  - lit only while D3 is displayed and the stale condition holds;
  - stale = ({`in`, `shift`, `lr`} != {`cap_val`, `cap_sh`, `cap_lr`});
  - `dp` is off on all other digits.
- **Output registers**: `seg`, `dp` and `an` are registered. No combinational path runs from any input to any output.
- **Polarity**: ACTIVE_LOW inversion is applied at the output register input.
- **Simultaneous events**:
  - `rst` takes priority over `load` and over counter terminal count.
  - A `load` on the same edge as a digit advance captures normally. The new digit shows the new data one cycle later.
- **Reset mid-scan**: the counter, index and captures all clear on the same edge. Scanning restarts at D0 with a full REFRESH_DIV dwell.

## Timing
- **Output reset values** (from the edge with `rst`=1), ACTIVE_LOW=1:
  - `an`=4'b1110;
  - `seg`=7'b1000000 (digit "0");
  - `dp`=1 (off).
- **Output reset values**, ACTIVE_LOW=0:
  - `an`=4'b0001;
  - `seg`=7'b0111111;
  - `dp`=0.
- **Load to display latency**: with `load` high at edge N, the capture registers update at N, and `seg` reflects the new value at edge N+1 if that digit is selected.
- **Digit dwell**: the index changes at the terminal-count edge, and `an`/`seg` change one edge later. Each digit is lit for exactly REFRESH_DIV cycles. The full scan period is 4*REFRESH_DIV.
- **Stale indicator**: `dp` responds to an `in` change one edge after the change, but only while D3 is displayed.

## Test plan
All scenarios use REFRESH_DIV=4 and ACTIVE_LOW=1.
1. **Reset values**: assert `rst` for 2 cycles → `an`=1110, `seg`=1000000, `dp`=1. The first `an` change comes 4 cycles after `rst` deasserts, to 1101.
2. **Capture and decode**: load `in`=8'b10011010, `shift`=0, `lr`=0 → expected per digit:
   - D0 `seg`=0001000 (A);
   - D1 `seg`=0010000 (9);
   - D2 `seg`=1000000 (0);
   - D3 `seg`=1000111 (L);
   - `dp`=1 throughout.
3. **Scan sequence**: run 32 cycles with no load → `an` cycles 1110, 1101, 1011, 0111, each held exactly 4 cycles, and the pattern repeats twice.
4. **Direction and maximum shift**: load `shift`=7, `lr`=1 → D2 `seg`=1111000 (7), D3 `seg`=0101111 (r).
5. **Stale indicator**:
   - after a load, change `in` to 8'h35 without `load` → `dp`=0 only while `an`=0111, and displayed digits are unchanged;
   - pulse `load` → `dp`=1 from the next edge onward.
6. **Reset priority and mid-scan reset**: assert `rst` and `load` together while D2 is displayed → captures stay 0, the next edge gives the reset output values, and a full 4-cycle D0 dwell follows.
